car_layer_compositor: RTL and testbench

- Pixel-side consumer of the car sprite modules.
- Takes the per-pixel colors from the player car and N AI cars (each outputs MASK_VALUE 8'h62 where transparent) and merges them by priority over the road background into one VGA color.
- Detects pixel-accurate player/AI overlap, latches it per frame, and runs the crash/recover sequence that the game logic and speed controller consume.

---
 rtl/car_pkg.sv | 21 ++
 rtl/crash_fsm.sv | 121 ++++++++++++
 rtl/car_layer_compositor.sv | 97 +++++++++
 tb/tb_car_layer_compositor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared types and constants for the car sprite pipeline.
// Sprite modules and the layer compositor agree on the transparent color
// code and the crash/recover timing defined here.
package car_pkg;

  typedef logic [7:0] color_t;

  // Color code that every sprite module emits for a transparent pixel.
  localparam color_t MASK_VALUE = 8'h62;

  // Default lengths, in frames, of the crash and invulnerable recover phases.
  localparam logic [7:0] DEFAULT_CRASH_FRAMES   = 8'd60;
  localparam logic [7:0] DEFAULT_RECOVER_FRAMES = 8'd90;

  typedef enum logic [1:0] {
    DRIVE   = 2'd0,
    CRASH   = 2'd1,
    RECOVER = 2'd2
  } crash_state_t;

endpackage

// File: rtl/crash_fsm.sv
// Crash sequencer: latches player/AI overlap per frame and steps through
// DRIVE -> CRASH -> RECOVER -> DRIVE, moving only on frame_start.
// The frame counter holds the number of frame_starts remaining in the
// current phase minus one. state and counter are exposed for the blink
// logic and for debug.
module crash_fsm
  import car_pkg::*;
#(
  parameter logic [7:0] CRASH_FRAMES   = DEFAULT_CRASH_FRAMES,
  parameter logic [7:0] RECOVER_FRAMES = DEFAULT_RECOVER_FRAMES
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         frame_start,
  input  logic         pixel_hit,
  output logic         crash_pulse,
  output logic         crash_active,
  output logic         recovering,
  output logic [7:0]   hit_count,
  output crash_state_t state,
  output logic [7:0]   counter
);

  crash_state_t r_state, w_next_state;
  logic [7:0]   r_counter, w_next_counter;
  logic         r_frame_hit, w_next_frame_hit;
  logic         w_declare;
  logic         w_hit_ok;
  logic         r_crash_pulse, r_crash_active, r_recovering;
  logic [7:0]   r_hit_count;
  logic         w_crash_active_d, w_recovering_d;
  logic [7:0]   w_hit_count_d;

  // Hits only count while driving; a hit on the frame_start cycle belongs
  // to the new frame, so the sticky flag is reloaded rather than cleared.
  assign w_hit_ok         = pixel_hit && (r_state == DRIVE);
  assign w_next_frame_hit = frame_start ? w_hit_ok : (r_frame_hit | w_hit_ok);

  // State register: state, frame counter and per-frame hit flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= DRIVE;
      r_counter   <= 8'd0;
      r_frame_hit <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_counter   <= w_next_counter;
      r_frame_hit <= w_next_frame_hit;
    end
  end

  // Next-state logic: evaluated only at frame boundaries.
  always_comb begin
    w_next_state   = r_state;
    w_next_counter = r_counter;
    w_declare      = 1'b0;
    if (frame_start) begin
      case (r_state)
        DRIVE: begin
          if (r_frame_hit) begin
            w_next_state   = CRASH;
            w_next_counter = CRASH_FRAMES - 8'd1;
            w_declare      = 1'b1;
          end
        end
        CRASH: begin
          if (r_counter == 8'd0) begin
            w_next_state   = RECOVER;
            w_next_counter = RECOVER_FRAMES - 8'd1;
          end else begin
            w_next_counter = r_counter - 8'd1;
          end
        end
        RECOVER: begin
          if (r_counter == 8'd0) begin
            w_next_state = DRIVE;
          end else begin
            w_next_counter = r_counter - 8'd1;
          end
        end
        default: begin
          w_next_state   = DRIVE;
          w_next_counter = 8'd0;
        end
      endcase
    end
  end

  // Output logic: next values of the registered status outputs.
  always_comb begin
    w_crash_active_d = (w_next_state == CRASH);
    w_recovering_d   = (w_next_state == RECOVER);
    w_hit_count_d    = r_hit_count;
    if (w_declare && (r_hit_count != 8'hff)) begin
      w_hit_count_d = r_hit_count + 8'd1;
    end
  end

  // Output registers so every status output comes straight from a flop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_crash_pulse  <= 1'b0;
      r_crash_active <= 1'b0;
      r_recovering   <= 1'b0;
      r_hit_count    <= 8'd0;
    end else begin
      r_crash_pulse  <= w_declare;
      r_crash_active <= w_crash_active_d;
      r_recovering   <= w_recovering_d;
      r_hit_count    <= w_hit_count_d;
    end
  end

  assign crash_pulse  = r_crash_pulse;
  assign crash_active = r_crash_active;
  assign recovering   = r_recovering;
  assign hit_count    = r_hit_count;
  assign state        = r_state;
  assign counter      = r_counter;

endmodule

// File: rtl/car_layer_compositor.sv
// Car layer compositor: merges player and AI sprite colors over the road
// background by fixed priority (player, AI 0..NUM_AI-1, background) with a
// one-cycle registered latency, and feeds pixel-accurate player/AI overlap
// into the crash sequencer.
// Optional build macro COMPOSITOR_BLINK_EN: blinks the player sprite
// (4 frames off, 4 on, from counter bit 2) while recovering.
module car_layer_compositor
  import car_pkg::color_t, car_pkg::crash_state_t;
#(
  parameter int         NUM_AI         = 3,
  parameter color_t     MASK_VALUE     = car_pkg::MASK_VALUE,
  parameter logic [7:0] CRASH_FRAMES   = car_pkg::DEFAULT_CRASH_FRAMES,
  parameter logic [7:0] RECOVER_FRAMES = car_pkg::DEFAULT_RECOVER_FRAMES
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [7:0]             player_color,
  input  logic [NUM_AI-1:0][7:0] ai_color,
  input  logic [7:0]             bg_color,
  output logic [7:0]             out_color,
  output logic                   out_valid,
  output logic                   crash_pulse,
  output logic                   crash_active,
  output logic                   recovering,
  output logic [7:0]             hit_count
);

  color_t       w_player_eff;
  color_t       w_mux;
  logic         w_any_ai;
  logic         w_pixel_hit;
  crash_state_t w_state;
  logic [7:0]   w_counter;
  color_t       r_out_color;
  logic         r_out_valid;

`ifdef COMPOSITOR_BLINK_EN
  // Blinking is purely visual; hit detection still uses the raw player color.
  assign w_player_eff = ((w_state == car_pkg::RECOVER) && w_counter[2]) ? MASK_VALUE
                                                                         : player_color;
`else
  logic w_unused_fsm_dbg;
  assign w_player_eff     = player_color;
  assign w_unused_fsm_dbg = ^{w_state, w_counter};
`endif

  // Priority mux: scan AI from lowest to highest priority so index 0 wins,
  // then let a visible player override everything.
  always_comb begin
    w_mux    = bg_color;
    w_any_ai = 1'b0;
    for (int k = NUM_AI - 1; k >= 0; k--) begin
      if (ai_color[k] != MASK_VALUE) begin
        w_mux    = ai_color[k];
        w_any_ai = 1'b1;
      end
    end
    if (w_player_eff != MASK_VALUE) begin
      w_mux = w_player_eff;
    end
  end

  assign w_pixel_hit = pixel_valid && (player_color != MASK_VALUE) && w_any_ai;

  // Output stage: one cycle of latency, blank outside the visible area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_out_color <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_color <= pixel_valid ? w_mux : 8'h00;
      r_out_valid <= pixel_valid;
    end
  end

  assign out_color = r_out_color;
  assign out_valid = r_out_valid;

  crash_fsm #(
    .CRASH_FRAMES   (CRASH_FRAMES),
    .RECOVER_FRAMES (RECOVER_FRAMES)
  ) u_crash_fsm (
    .clk          (clk),
    .resetN       (resetN),
    .frame_start  (frame_start),
    .pixel_hit    (w_pixel_hit),
    .crash_pulse  (crash_pulse),
    .crash_active (crash_active),
    .recovering   (recovering),
    .hit_count    (hit_count),
    .state        (w_state),
    .counter      (w_counter)
  );

endmodule

// File: tb/tb_car_layer_compositor.sv
// Directed bench for car_layer_compositor: compositing priority and
// masking, crash declaration, CRASH/RECOVER lengths, frame_start-coincident
// hits and asynchronous reset during a crash.
module tb_car_layer_compositor;

  logic             clk = 1'b0;
  logic             resetN;
  logic             frame_start;
  logic             pixel_valid;
  logic [7:0]       player_color;
  logic [2:0][7:0]  ai_color;
  logic [7:0]       bg_color;
  logic [7:0]       out_color;
  logic             out_valid;
  logic             crash_pulse;
  logic             crash_active;
  logic             recovering;
  logic [7:0]       hit_count;

  int tests = 0;
  int fails = 0;

  car_layer_compositor dut (
    .clk          (clk),
    .resetN       (resetN),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .player_color (player_color),
    .ai_color     (ai_color),
    .bg_color     (bg_color),
    .out_color    (out_color),
    .out_valid    (out_valid),
    .crash_pulse  (crash_pulse),
    .crash_active (crash_active),
    .recovering   (recovering),
    .hit_count    (hit_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic pv, input logic [7:0] pl, input logic [7:0] a0,
                    input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] bg);
    pixel_valid  = pv;
    player_color = pl;
    ai_color[0]  = a0;
    ai_color[1]  = a1;
    ai_color[2]  = a2;
    bg_color     = bg;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    px(1'b0, 8'h62, 8'h62, 8'h62, 8'h62, 8'h00);
  endtask

  // Optional overlap pixel (player ff over ai[2] e4), then a frame_start cycle.
  task automatic frame(input bit ovl, input logic [7:0] exp_col);
    if (ovl) begin
      frame_start = 1'b0;
      px(1'b1, 8'hff, 8'h62, 8'h62, 8'he4, 8'h24);
      tick();
      chk("overlap_color", out_color, exp_col);
    end
    idle();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [7:0] col;
    logic [7:0] rcnt;

    // reset
    resetN = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_out_color", out_color, 8'h00);
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_crash_pulse", {7'd0, crash_pulse}, 8'h00);
    chk("rst_crash_active", {7'd0, crash_active}, 8'h00);
    chk("rst_recovering", {7'd0, recovering}, 8'h00);
    chk("rst_hit_count", hit_count, 8'h00);
    #2 resetN = 1'b1;
    tick();

    // compositing priority
    px(1'b1, 8'h62, 8'he4, 8'h00, 8'h62, 8'h24);
    tick();
    chk("ai0_wins", out_color, 8'he4);
    chk("ai0_valid", {7'd0, out_valid}, 8'h01);
    px(1'b1, 8'h62, 8'h62, 8'h62, 8'h62, 8'h24);
    tick();
    chk("bg_wins", out_color, 8'h24);
    px(1'b1, 8'h62, 8'h62, 8'h62, 8'h62, 8'h62);
    tick();
    chk("bg_mask_passthru", out_color, 8'h62);
    px(1'b1, 8'h62, 8'h62, 8'h00, 8'h1c, 8'h24);
    tick();
    chk("ai1_black_wins", out_color, 8'h00);
    px(1'b1, 8'h62, 8'h62, 8'h62, 8'h1c, 8'h24);
    tick();
    chk("ai2_wins", out_color, 8'h1c);
    px(1'b0, 8'h62, 8'h62, 8'h62, 8'h62, 8'h24);
    tick();
    chk("invisible_color", out_color, 8'h00);
    chk("invisible_valid", {7'd0, out_valid}, 8'h00);
    chk("no_crash_yet", {7'd0, crash_active}, 8'h00);

    // single overlap pixel then frame_start declares a crash
    frame(1'b1, 8'hff);
    chk("crash1_pulse", {7'd0, crash_pulse}, 8'h01);
    chk("crash1_active", {7'd0, crash_active}, 8'h01);
    chk("crash1_hits", hit_count, 8'h01);
    idle();
    tick();
    chk("crash1_pulse_once", {7'd0, crash_pulse}, 8'h00);

    // CRASH lasts 60 frame_starts, even with overlap every frame
    for (int i = 1; i <= 60; i++) begin
      frame(1'b1, 8'hff);
      chk("crash_active_len", {7'd0, crash_active}, (i < 60) ? 8'h01 : 8'h00);
      chk("crash_recover_entry", {7'd0, recovering}, (i < 60) ? 8'h00 : 8'h01);
      chk("crash_no_pulse", {7'd0, crash_pulse}, 8'h00);
    end

    // RECOVER lasts 90 frame_starts; overlap is ignored
    for (int j = 1; j <= 90; j++) begin
      rcnt = 8'(90 - j);
`ifdef COMPOSITOR_BLINK_EN
      col = rcnt[2] ? 8'he4 : 8'hff;
`else
      col = (rcnt == rcnt) ? 8'hff : 8'hff;
      col = 8'hff;
`endif
      frame(1'b1, col);
      chk("recover_len", {7'd0, recovering}, (j < 90) ? 8'h01 : 8'h00);
      chk("recover_no_crash", {7'd0, crash_active}, 8'h00);
      chk("recover_no_pulse", {7'd0, crash_pulse}, 8'h00);
    end
    chk("recover_hits_held", hit_count, 8'h01);

    // back in DRIVE: next overlapping frame crashes again
    frame(1'b1, 8'hff);
    chk("crash2_pulse", {7'd0, crash_pulse}, 8'h01);
    chk("crash2_active", {7'd0, crash_active}, 8'h01);
    chk("crash2_hits", hit_count, 8'h02);

    // advance CRASH until the counter reads 30, then reset mid-frame
    for (int i = 0; i < 29; i++) begin
      frame(1'b0, 8'h00);
    end
    chk("mid_crash_active", {7'd0, crash_active}, 8'h01);
    px(1'b1, 8'hff, 8'h62, 8'h62, 8'he4, 8'h24);
    tick();
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_out_color", out_color, 8'h00);
    chk("async_rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("async_rst_active", {7'd0, crash_active}, 8'h00);
    chk("async_rst_recovering", {7'd0, recovering}, 8'h00);
    chk("async_rst_pulse", {7'd0, crash_pulse}, 8'h00);
    chk("async_rst_hits", hit_count, 8'h00);
    idle();
    tick();
    resetN = 1'b1;
    tick();
    frame(1'b0, 8'h00);
    chk("post_rst_no_crash", {7'd0, crash_active}, 8'h00);

    // overlap on the frame_start cycle counts toward the next frame
    frame_start = 1'b1;
    px(1'b1, 8'hff, 8'h62, 8'h62, 8'he4, 8'h24);
    tick();
    chk("coincident_no_pulse", {7'd0, crash_pulse}, 8'h00);
    chk("coincident_no_active", {7'd0, crash_active}, 8'h00);
    idle();
    tick();
    frame(1'b0, 8'h00);
    chk("coincident_next_pulse", {7'd0, crash_pulse}, 8'h01);
    chk("coincident_next_active", {7'd0, crash_active}, 8'h01);
    chk("coincident_next_hits", hit_count, 8'h01);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
